// File: rtl/dmem_responder.sv
// Data-memory responder: 64-bit synchronous RAM behind a pipelined AHB-style slave port
// with programmable wait states, two-cycle error response and write-to-read forwarding.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SpanBytes = 64'(DEPTH_WORDS) << 3;
    localparam logic [2:0]  CntLoad   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLast,
        StErr1,
        StErr2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [2:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            write_q, write_d;
    logic [63:0]     rdata_q, rdata_d;

    logic [63:0]     mem [DEPTH_WORDS];

    logic [63:0]     offset;
    logic            misalign;
    logic            err_in;
    logic            accept;
    logic [IdxW-1:0] idx_in;

    logic [7:0]      be_base;
    logic [7:0]      be;
    logic [63:0]     wdata_sh;
    logic            wr_en;
    logic [63:0]     cur_word;
    logic [63:0]     wr_merged;

    logic            rd_load;
    logic [IdxW-1:0] rd_idx;
    logic            rd_is_read;
    logic [63:0]     rd_word;
    logic [63:0]     rd_fwd;
    logic            fwd_hit;

    // Address decode; addresses below BASE_ADDR wrap to a huge offset and fail the range check.
    always_comb begin
        offset = HADDR - BASE_ADDR;
        idx_in = offset[IdxW+2:3];
        case (HSIZE)
            3'd0:    misalign = 1'b0;
            3'd1:    misalign = HADDR[0];
            3'd2:    misalign = |HADDR[1:0];
            3'd3:    misalign = |HADDR[2:0];
            default: misalign = 1'b0;
        endcase
        err_in = (offset >= SpanBytes) | misalign | HSIZE[2];
        accept = HTRANS & HREADY;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            off_q   <= 3'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            StIdle, StLast, StErr2: begin
                if (accept) begin
                    idx_d   = idx_in;
                    off_d   = HADDR[2:0];
                    size_d  = HSIZE[1:0];
                    write_d = HWRITE;
                    if (err_in) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d = StLast;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StLast;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (state_q)
            StIdle: begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
            StWait: begin
                HREADY = 1'b0;
                HRESP  = 1'b0;
            end
            StLast: begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
            StErr1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            StErr2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            default: begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
        endcase
    end

    assign HRDATA = rdata_q;

    // Write datapath: commit happens on the edge that ends LAST.
    always_comb begin
        case (size_q)
            2'd0:    be_base = 8'h01;
            2'd1:    be_base = 8'h03;
            2'd2:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
        be        = be_base << off_q;
        wdata_sh  = HWDATA << {off_q, 3'b000};
        wr_en     = (state_q == StLast) & write_q;
        cur_word  = mem[idx_q];
        wr_merged = cur_word;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) begin
                wr_merged[8*b +: 8] = wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[idx_q] <= wr_merged;
        end
    end

    // Read datapath: LAST is entered either from WAIT (latched transfer) or straight from accept.
    always_comb begin
        if (state_q == StWait) begin
            rd_idx     = idx_q;
            rd_is_read = !write_q;
        end else begin
            rd_idx     = idx_in;
            rd_is_read = !HWRITE;
        end
        rd_load = (state_d == StLast) & rd_is_read;
        rd_word = mem[rd_idx];
        fwd_hit = wr_en & (idx_q == rd_idx);
        rd_fwd  = rd_word;
        for (int b = 0; b < 8; b++) begin
            if (fwd_hit && be[b]) begin
                rd_fwd[8*b +: 8] = wdata_sh[8*b +: 8];
            end
        end
        rdata_d = rd_load ? rd_fwd : rdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        htrans [2];
    logic [63:0] haddr  [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [63:0] hwdata [2];
    logic [63:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(
        .DEPTH_WORDS(512),
        .BASE_ADDR  (64'h8000_0000),
        .WAIT_STATES(1)
    ) u_dut_ws1 (
        .CLK   (clk),
        .RESET (rst_n),
        .HTRANS(htrans[0]),
        .HADDR (haddr[0]),
        .HWRITE(hwrite[0]),
        .HSIZE (hsize[0]),
        .HWDATA(hwdata[0]),
        .HRDATA(hrdata[0]),
        .HREADY(hready[0]),
        .HRESP (hresp[0])
    );

    dmem_responder #(
        .DEPTH_WORDS(512),
        .BASE_ADDR  (64'h8000_0000),
        .WAIT_STATES(0)
    ) u_dut_ws0 (
        .CLK   (clk),
        .RESET (rst_n),
        .HTRANS(htrans[1]),
        .HADDR (haddr[1]),
        .HWRITE(hwrite[1]),
        .HSIZE (hsize[1]),
        .HWDATA(hwdata[1]),
        .HRDATA(hrdata[1]),
        .HREADY(hready[1]),
        .HRESP (hresp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic        wr;
        logic [63:0] addr;
        logic [2:0]  sz;
        logic [63:0] wd;
        int          low;
        logic        resp;
        logic        chk;
        logic [63:0] rd;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Single non-pipelined transfer; reports HREADY-low cycles, HRESP seen, and HRDATA at completion.
    task automatic xfer(input int d, input logic wr, input logic [63:0] addr, input logic [2:0] sz,
                        input logic [63:0] wd, output int lows, output logic r_and,
                        output logic r_or, output logic [63:0] rdata, output logic to);
        logic acc;
        logic done;
        acc   = 1'b0;
        done  = 1'b0;
        lows  = 0;
        r_and = 1'b1;
        r_or  = 1'b0;
        rdata = 64'd0;
        htrans[d] = 1'b1;
        hwrite[d] = wr;
        haddr[d]  = addr;
        hsize[d]  = sz;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (hready[d]) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        htrans[d] = 1'b0;
        hwdata[d] = wd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r_and = r_and & hresp[d];
            r_or  = r_or | hresp[d];
            if (hready[d]) begin
                rdata = hrdata[d];
                done  = 1'b1;
                break;
            end
            lows++;
        end
        @(posedge clk);
        #1;
        to = !(acc && done);
    endtask

    initial begin
        int          lows;
        logic        r_and;
        logic        r_or;
        logic [63:0] rdata;
        logic        to;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            htrans[d] = 1'b0;
            haddr[d]  = 64'd0;
            hwrite[d] = 1'b0;
            hsize[d]  = 3'd0;
            hwdata[d] = 64'd0;
        end

        // d, wr, addr, size, wdata, hready-low cycles, hresp, check rdata, rdata
        vt.push_back('{0, 1'b1, 64'h8000_0010, 3'd3, 64'h1122_3344_5566_7788, 1, 1'b0, 1'b0, 64'h0});
        vt.push_back('{0, 1'b0, 64'h8000_0010, 3'd3, 64'h0, 1, 1'b0, 1'b1, 64'h1122_3344_5566_7788});
        vt.push_back('{0, 1'b1, 64'h8000_0000, 3'd3, 64'h0, 1, 1'b0, 1'b0, 64'h0});
        vt.push_back('{0, 1'b1, 64'h8000_0003, 3'd0, 64'hAB, 1, 1'b0, 1'b0, 64'h0});
        vt.push_back('{0, 1'b1, 64'h8000_0006, 3'd1, 64'hBEEF, 1, 1'b0, 1'b0, 64'h0});
        vt.push_back('{0, 1'b0, 64'h8000_0000, 3'd3, 64'h0, 1, 1'b0, 1'b1, 64'hBEEF_0000_AB00_0000});
        vt.push_back('{0, 1'b1, 64'h8000_0001, 3'd1, 64'hFFFF, 1, 1'b1, 1'b0, 64'h0});
        vt.push_back('{0, 1'b0, 64'h8000_0000, 3'd3, 64'h0, 1, 1'b0, 1'b1, 64'hBEEF_0000_AB00_0000});
        vt.push_back('{0, 1'b0, 64'h8000_1000, 3'd3, 64'h0, 1, 1'b1, 1'b1, 64'hBEEF_0000_AB00_0000});
        vt.push_back('{0, 1'b1, 64'h8000_0010, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 1'b0, 64'h0});
        vt.push_back('{0, 1'b1, 64'h8000_0FF8, 3'd3, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b0, 64'h0});
        vt.push_back('{0, 1'b0, 64'h8000_0FF8, 3'd3, 64'h0, 1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF});
        vt.push_back('{0, 1'b0, 64'h7FFF_FFF8, 3'd3, 64'h0, 1, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF});
        vt.push_back('{0, 1'b0, 64'h8000_0010, 3'd3, 64'h0, 1, 1'b0, 1'b1, 64'h1122_3344_5566_7788});
        vt.push_back('{1, 1'b1, 64'h8000_0010, 3'd3, 64'h0, 0, 1'b0, 1'b0, 64'h0});
        vt.push_back('{1, 1'b0, 64'h8000_0002, 3'd2, 64'h0, 1, 1'b1, 1'b1, 64'h0});

        #12;
        chk("reset_hready", {63'd0, hready[0]}, 64'd1);
        chk("reset_hresp", {63'd0, hresp[0]}, 64'd0);
        chk("reset_hrdata", hrdata[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            xfer(vt[i].d, vt[i].wr, vt[i].addr, vt[i].sz, vt[i].wd, lows, r_and, r_or, rdata, to);
            chk($sformatf("v%0d_timeout", i), {63'd0, to}, 64'd0);
            chk($sformatf("v%0d_ready_low", i), 64'(lows), 64'(vt[i].low));
            chk($sformatf("v%0d_hresp", i), {62'd0, r_and, r_or}, {62'd0, vt[i].resp, vt[i].resp});
            if (vt[i].chk) begin
                chk($sformatf("v%0d_hrdata", i), rdata, vt[i].rd);
            end
        end

        // Back-to-back write then read of the same word with no wait states.
        htrans[1] = 1'b1;
        hwrite[1] = 1'b1;
        haddr[1]  = 64'h8000_0014;
        hsize[1]  = 3'd2;
        @(negedge clk);
        chk("b2b_ready_a", {63'd0, hready[1]}, 64'd1);
        @(posedge clk);
        #1;
        hwdata[1] = 64'hDEAD_BEEF;
        hwrite[1] = 1'b0;
        haddr[1]  = 64'h8000_0010;
        hsize[1]  = 3'd3;
        @(negedge clk);
        chk("b2b_ready_w", {63'd0, hready[1]}, 64'd1);
        @(posedge clk);
        #1;
        htrans[1] = 1'b0;
        @(negedge clk);
        chk("b2b_ready_r", {63'd0, hready[1]}, 64'd1);
        chk("b2b_fwd_data", hrdata[1], 64'hDEAD_BEEF_0000_0000);
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 64'h8000_0010, 3'd3, 64'h0, lows, r_and, r_or, rdata, to);
        chk("b2b_commit_to", {63'd0, to}, 64'd0);
        chk("b2b_commit_data", rdata, 64'hDEAD_BEEF_0000_0000);

        // Reset pulse during the wait state of a write drops the write.
        htrans[0] = 1'b1;
        hwrite[0] = 1'b1;
        haddr[0]  = 64'h8000_0010;
        hsize[0]  = 3'd3;
        @(negedge clk);
        chk("rst_ready_idle", {63'd0, hready[0]}, 64'd1);
        @(posedge clk);
        #1;
        htrans[0] = 1'b0;
        hwdata[0] = 64'h5555_5555_5555_5555;
        @(negedge clk);
        chk("rst_in_wait", {63'd0, hready[0]}, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_hready", {63'd0, hready[0]}, 64'd1);
        chk("rst_hresp", {63'd0, hresp[0]}, 64'd0);
        chk("rst_hrdata", hrdata[0], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(0, 1'b0, 64'h8000_0010, 3'd3, 64'h0, lows, r_and, r_or, rdata, to);
        chk("rst_after_to", {63'd0, to}, 64'd0);
        chk("rst_after_data", rdata, 64'h1122_3344_5566_7788);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
